color_avg_filter: RTL and testbench

COLOR_AVG_FILTER -- requirements
Module: color_avg_filter

---
 rtl/color_avg_filter.sv | 147 ++++++++++++++
 tb/tb_color_avg_filter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/color_avg_filter.sv
// Purpose: boxcar-averages RGB sensor samples over 2^AVG_LOG2-sample windows for the display path.
// Latency: last sample handshake at edge k -> averages and update_o visible after edge k+1.
// Backpressure: s_ready_o drops for exactly one cycle per window (PUBLISH) and is low during reset.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   s_valid_i / s_ready_o         sample handshake
//   s_red_i/s_green_i/s_blue_i    raw sensor channels (COLOR_WIDTH bits)
//   flush_i                       drop the partial window (ignored while publishing)
//   red_o/green_o/blue_o          last published averages, held between updates
//   update_o                      one-cycle pulse when new averages appear
//   sat_o                         saturation flag of the last published window
//
// Optional feature: define COLOR_AVG_SAT_EN to build the per-window saturation
// detector; without it sat_o is tied to 0.
module color_avg_filter #(
    parameter int COLOR_WIDTH = 16,
    parameter int AVG_LOG2    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [COLOR_WIDTH-1:0] s_red_i,
    input  logic [COLOR_WIDTH-1:0] s_green_i,
    input  logic [COLOR_WIDTH-1:0] s_blue_i,
    input  logic                   flush_i,
    output logic [COLOR_WIDTH-1:0] red_o,
    output logic [COLOR_WIDTH-1:0] green_o,
    output logic [COLOR_WIDTH-1:0] blue_o,
    output logic                   update_o,
    output logic                   sat_o
);

    localparam int ACC_W = COLOR_WIDTH + AVG_LOG2;
    // One spare bit so the counter can hold the full window count.
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {ACCUM, PUBLISH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc_red;
    logic [ACC_W-1:0]  acc_green;
    logic [ACC_W-1:0]  acc_blue;
    logic [CNT_W-1:0]  cnt;
    logic              handshake;
    logic              take;
    logic              last;
    logic              publish;

    assign handshake = s_valid_i & s_ready_o;
    // A flush coinciding with a handshake wins: the sample is dropped.
    assign take      = handshake & ~flush_i;
    assign last      = take & (cnt == LAST_IDX);
    assign publish   = (state == PUBLISH);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready_o = 1'b0;
        case (state)
            ACCUM: begin
                // Reset forces ACCUM, so gate ready with rst_i to keep it low during reset.
                s_ready_o = ~rst_i;
                if (last) state_nxt = PUBLISH;
            end
            PUBLISH: begin
                state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // ---------------- accumulators ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_red   <= '0;
            acc_green <= '0;
            acc_blue  <= '0;
            cnt       <= '0;
        end else if (publish || flush_i) begin
            // In PUBLISH the flush is irrelevant: the window clears anyway.
            acc_red   <= '0;
            acc_green <= '0;
            acc_blue  <= '0;
            cnt       <= '0;
        end else if (take) begin
            acc_red   <= acc_red   + ACC_W'(s_red_i);
            acc_green <= acc_green + ACC_W'(s_green_i);
            acc_blue  <= acc_blue  + ACC_W'(s_blue_i);
            cnt       <= cnt + 1'b1;
        end
    end

    // ---------------- published outputs ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            red_o    <= '0;
            green_o  <= '0;
            blue_o   <= '0;
            update_o <= 1'b0;
        end else begin
            update_o <= publish;
            if (publish) begin
                // Dropping the low AVG_LOG2 bits is the truncating divide.
                red_o   <= acc_red[ACC_W-1:AVG_LOG2];
                green_o <= acc_green[ACC_W-1:AVG_LOG2];
                blue_o  <= acc_blue[ACC_W-1:AVG_LOG2];
            end
        end
    end

    // ---------------- saturation flag ----------------
`ifdef COLOR_AVG_SAT_EN
    logic sat_acc;
    logic sample_sat;

    assign sample_sat = (&s_red_i) | (&s_green_i) | (&s_blue_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_acc <= 1'b0;
            sat_o   <= 1'b0;
        end else begin
            if (publish) sat_o <= sat_acc;
            if (publish || flush_i) begin
                sat_acc <= 1'b0;
            end else if (take && sample_sat) begin
                sat_acc <= 1'b1;
            end
        end
    end
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_color_avg_filter.sv
// Purpose: directed self-checking bench for color_avg_filter (COLOR_WIDTH=16, AVG_LOG2=2).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: sample pushes wait (bounded) for s_ready_o before completing a handshake.
module tb_color_avg_filter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [15:0] s_red_i = '0;
    logic [15:0] s_green_i = '0;
    logic [15:0] s_blue_i = '0;
    logic        flush_i = 1'b0;
    logic [15:0] red_o;
    logic [15:0] green_o;
    logic [15:0] blue_o;
    logic        update_o;
    logic        sat_o;

    int checks = 0;
    int passed = 0;

`ifdef COLOR_AVG_SAT_EN
    localparam logic SAT_EXP = 1'b1;
`else
    localparam logic SAT_EXP = 1'b0;
`endif

    color_avg_filter #(.COLOR_WIDTH(16), .AVG_LOG2(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_red_i   (s_red_i),
        .s_green_i (s_green_i),
        .s_blue_i  (s_blue_i),
        .flush_i   (flush_i),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o),
        .update_o  (update_o),
        .sat_o     (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One sample through the handshake; returns 1 time unit after the accepting edge.
    task automatic push(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        int n;
        n = 0;
        s_valid_i = 1'b1;
        s_red_i   = r;
        s_green_i = g;
        s_blue_i  = b;
        while (!s_ready_o && n < 8) begin
            tick();
            n++;
        end
        if (n == 8) check("ready_timeout", 16'(s_ready_o), 16'd1);
        tick();
        s_valid_i = 1'b0;
    endtask

    // Idle cycles during which the published outputs must hold.
    task automatic idle(input int n, input logic [15:0] r_hold);
        for (int i = 0; i < n; i++) begin
            tick();
            check("gap_update", 16'(update_o), 16'd0);
            check("gap_red_hold", red_o, r_hold);
        end
    endtask

    // Called right after the last handshake of a window.
    task automatic expect_publish(input string tag, input logic [15:0] r, input logic [15:0] g,
                                  input logic [15:0] b, input logic s);
        check({tag, "_bubble"}, 16'(s_ready_o), 16'd0);
        check({tag, "_no_early_upd"}, 16'(update_o), 16'd0);
        tick();
        check({tag, "_update"}, 16'(update_o), 16'd1);
        check({tag, "_ready_back"}, 16'(s_ready_o), 16'd1);
        check({tag, "_red"}, red_o, r);
        check({tag, "_green"}, green_o, g);
        check({tag, "_blue"}, blue_o, b);
        check({tag, "_sat"}, 16'(sat_o), 16'(s));
        tick();
        check({tag, "_pulse_end"}, 16'(update_o), 16'd0);
        check({tag, "_red_hold"}, red_o, r);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ready", 16'(s_ready_o), 16'd0);
        check("rst_red", red_o, 16'd0);
        check("rst_update", 16'(update_o), 16'd0);
        check("rst_sat", 16'(sat_o), 16'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 16'(s_ready_o), 16'd1);

        // 100..400 -> 250
        push(16'd100, 16'd0, 16'd0);
        push(16'd200, 16'd0, 16'd0);
        push(16'd300, 16'd0, 16'd0);
        push(16'd400, 16'd0, 16'd0);
        expect_publish("avg250", 16'd250, 16'd0, 16'd0, 1'b0);

        // Truncation: (1+1+1+2)/4 = 1
        push(16'd0, 16'd0, 16'd1);
        push(16'd0, 16'd0, 16'd1);
        push(16'd0, 16'd0, 16'd1);
        push(16'd0, 16'd0, 16'd2);
        expect_publish("trunc", 16'd0, 16'd0, 16'd1, 1'b0);

        // All-ones: no wrap in the accumulator
        for (int i = 0; i < 4; i++) push(16'hFFFF, 16'hFFFF, 16'hFFFF);
        expect_publish("allones", 16'hFFFF, 16'hFFFF, 16'hFFFF, SAT_EXP);

        // Flush together with the 3rd sample, then 4 x 40
        push(16'd7, 16'd7, 16'd7);
        push(16'd7, 16'd7, 16'd7);
        s_valid_i = 1'b1;
        s_red_i   = 16'd999;
        flush_i   = 1'b1;
        tick();
        s_valid_i = 1'b0;
        flush_i   = 1'b0;
        check("flush_no_update", 16'(update_o), 16'd0);
        check("flush_red_hold", red_o, 16'hFFFF);
        for (int i = 0; i < 4; i++) push(16'd40, 16'd0, 16'd0);
        expect_publish("flush40", 16'd40, 16'd0, 16'd0, 1'b0);

        // Saturation on green only: (FFFF+0+0+0)/4 = 3FFF
        push(16'd0, 16'hFFFF, 16'd0);
        for (int i = 0; i < 3; i++) push(16'd0, 16'd0, 16'd0);
        expect_publish("satgreen", 16'd0, 16'h3FFF, 16'd0, SAT_EXP);
        for (int i = 0; i < 4; i++) push(16'd4, 16'd4, 16'd4);
        expect_publish("clean", 16'd4, 16'd4, 16'd4, 1'b0);

        // Reset after 3 samples discards the window
        for (int i = 0; i < 3; i++) push(16'd100, 16'd100, 16'd100);
        rst_i = 1'b1;
        #1;
        check("midrst_red", red_o, 16'd0);
        check("midrst_green", green_o, 16'd0);
        check("midrst_update", 16'(update_o), 16'd0);
        check("midrst_ready", 16'(s_ready_o), 16'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("midrst_no_pulse", 16'(update_o), 16'd0);
        for (int i = 0; i < 4; i++) push(16'd8, 16'd0, 16'd0);
        expect_publish("after_rst", 16'd8, 16'd0, 16'd0, 1'b0);

        // Gapped input: red 10,20,30,45 -> 26, green 5,6,7,8 -> 6
        push(16'd10, 16'd5, 16'd0);
        idle(int'($urandom_range(1, 4)), 16'd8);
        push(16'd20, 16'd6, 16'd0);
        idle(int'($urandom_range(1, 4)), 16'd8);
        push(16'd30, 16'd7, 16'd0);
        idle(int'($urandom_range(1, 4)), 16'd8);
        push(16'd45, 16'd8, 16'd0);
        expect_publish("gapped", 16'd26, 16'd6, 16'd0, 1'b0);

        // Flush during PUBLISH is ignored
        for (int i = 0; i < 4; i++) push(16'd12, 16'd0, 16'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("pubflush_update", 16'(update_o), 16'd1);
        check("pubflush_red", red_o, 16'd12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
